// File: rtl/bw_seq_mult_ctrl.sv
// Sequential signed AW x BW Baugh-Wooley multiplier controller.
// A single partial-product row is formed and added per cycle, so a product takes BW cycles.
module bw_seq_mult_ctrl #(
  parameter int AW = 7,
  parameter int BW = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [AW-1:0]           i_a,
  input  logic [BW-1:0]           i_b,
  input  logic                    i_abort,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [AW+BW-1:0]        o_p,
  output logic                    o_busy,
  output logic [$clog2(BW)-1:0]   o_row_idx
);

  localparam int PW = AW + BW;
  localparam int RW = $clog2(BW);

  // Correction constant folding in the complemented sign terms, modulo 2^PW
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << (AW-1)) + (PW'(1) << (BW-1)) + (PW'(1) << (PW-1));

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_a;
  logic [BW-1:0]   r_b;
  logic [PW-1:0]   r_acc;
  logic [RW-1:0]   r_row_idx;

  logic            w_last_row;
  logic            w_b_bit;
  logic [AW-1:0]   w_pp;
  logic [AW-1:0]   w_row;
  logic [PW-1:0]   w_row_shifted;

  assign w_last_row    = (r_row_idx == RW'(BW-1));
  assign w_b_bit       = r_b[r_row_idx];
  assign w_pp          = r_a & {AW{w_b_bit}};
  // Ordinary rows complement the sign-column bit; the multiplier's sign row complements the rest
  assign w_row         = w_last_row ? {w_pp[AW-1], ~w_pp[AW-2:0]}
                                    : {~w_pp[AW-1], w_pp[AW-2:0]};
  assign w_row_shifted = PW'(w_row) << r_row_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_in_valid) w_state_next = RUN;
      RUN:     if (i_abort) w_state_next = IDLE;
               else if (w_last_row) w_state_next = DONE;
      DONE:    if (i_abort || i_out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_row_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_a       <= i_a;
            r_b       <= i_b;
            r_acc     <= BW_CONST;
            r_row_idx <= '0;
          end
        end
        RUN: begin
          // An aborted operation leaves the partial sum visible but never flagged valid
          if (i_abort) begin
            r_row_idx <= '0;
          end else begin
            r_acc <= r_acc + w_row_shifted;
            if (!w_last_row) r_row_idx <= r_row_idx + RW'(1);
          end
        end
        DONE: begin
          if (i_abort || i_out_ready) r_row_idx <= '0;
        end
        default: r_row_idx <= '0;
      endcase
    end
  end

  assign o_in_ready  = (r_state == IDLE);
  assign o_busy      = (r_state == RUN);
  assign o_out_valid = (r_state == DONE);
  assign o_p         = r_acc;
  assign o_row_idx   = r_row_idx;

endmodule

// File: tb/tb_bw_seq_mult_ctrl.sv
// Scoreboard testbench for bw_seq_mult_ctrl: directed products, backpressure, abort,
// asynchronous reset and a full operand sweep against a signed reference.
module tb_bw_seq_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [6:0]  aIn = '0;
  logic [4:0]  bIn = '0;
  logic        abortReq = 1'b0;
  logic        outValid;
  logic        outReady = 1'b1;
  logic [11:0] pOut;
  logic        busy;
  logic [2:0]  rowIdx;

  int checkCount = 0;
  int errorCount = 0;
  int cycleCount = 0;
  logic [11:0] expQ[$];

  bw_seq_mult_ctrl #(.AW(7), .BW(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_a         (aIn),
    .i_b         (bIn),
    .i_abort     (abortReq),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_p         (pOut),
    .o_busy      (busy),
    .o_row_idx   (rowIdx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Signed reference product truncated to 12 bits
  function automatic logic [11:0] model(input int a, input int b);
    int pr;
    pr = a * b;
    return pr[11:0];
  endfunction

  // Presents operands from a falling edge, records the expected product, returns one falling edge after capture
  task automatic send_op(input int a, input int b, input logic [11:0] expV, output bit ok);
    int n;
    n = 0;
    aIn = 7'(a);
    bIn = 5'(b);
    inValid = 1'b1;
    while (!inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = inReady;
    if (ok) expQ.push_back(expV);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  // Counts falling edges until a product is offered, bounded
  task automatic wait_valid(output int n, output int busyCnt);
    n = 0;
    busyCnt = 0;
    while (!outValid && n < 100) begin
      if (busy) busyCnt++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    #3;
    checkCount++;
    if (outValid !== 1'b0 || busy !== 1'b0 || pOut !== 12'h000 || rowIdx !== 3'd0) begin
      errorCount++;
      $display("[TB] FAIL reset_outputs got valid=%b busy=%b p=%h row=%0d exp 0 0 000 0", outValid, busy, pOut, rowIdx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (inReady !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL reset_in_ready got %b exp 1", inReady);
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    int aT[5] = '{63, -64, -64, 0, 7};
    int bT[5] = '{15, -16, 15, -1, -3};
    logic [11:0] pT[5] = '{12'h3B1, 12'h400, 12'hC40, 12'h000, 12'hFEB};
    logic [11:0] expV;
    bit ok;
    int n, busyCnt;
    for (int i = 0; i < 5; i++) begin
      send_op(aT[i], bT[i], pT[i], ok);
      wait_valid(n, busyCnt);
      checkCount++;
      if (!ok || n != 5 || busyCnt != 5) begin
        errorCount++;
        $display("[TB] FAIL directed_latency[%0d] got accept=%0d lat=%0d busy=%0d exp 1 5 5", i, ok, n, busyCnt);
      end
      if (expQ.size() > 0) begin
        expV = expQ.pop_front();
        checkCount++;
        if (pOut !== expV) begin
          errorCount++;
          $display("[TB] FAIL directed_p[%0d] got %h exp %h", i, pOut, expV);
        end
      end
      @(negedge clk);
      checkCount++;
      if (outValid !== 1'b0 || inReady !== 1'b1) begin
        errorCount++;
        $display("[TB] FAIL directed_release[%0d] got valid=%b ready=%b exp 0 1", i, outValid, inReady);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] heldExp;
    bit ok;
    int n, busyCnt;
    outReady = 1'b0;
    send_op(10, -5, 12'hFCE, ok);
    wait_valid(n, busyCnt);
    checkCount++;
    if (n != 5 || expQ.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL bp_latency got %0d exp 5", n);
    end
    heldExp = (expQ.size() > 0) ? expQ.pop_front() : 12'hxxx;
    for (int c = 0; c < 10; c++) begin
      checkCount++;
      if (outValid !== 1'b1 || pOut !== heldExp || inReady !== 1'b0) begin
        errorCount++;
        $display("[TB] FAIL bp_hold[%0d] got valid=%b p=%h ready=%b exp 1 %h 0", c, outValid, pOut, inReady, heldExp);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkCount++;
    if (outValid !== 1'b0 || inReady !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL bp_release got valid=%b ready=%b exp 0 1", outValid, inReady);
    end
  endtask

  task automatic test_abort();
    logic [11:0] expV;
    bit ok, sawValid;
    int n, busyCnt;
    sawValid = 1'b0;
    send_op(5, 3, 12'h00F, ok);
    n = 0;
    while (rowIdx !== 3'd2 && n < 20) begin
      if (outValid) sawValid = 1'b1;
      @(negedge clk);
      n++;
    end
    checkCount++;
    if (rowIdx !== 3'd2 || busy !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL abort_reach_row2 got row=%0d busy=%b exp 2 1", rowIdx, busy);
    end
    if (expQ.size() > 0) void'(expQ.pop_back());
    abortReq = 1'b1;
    inValid = 1'b1;
    aIn = 7'(-7);
    bIn = 5'(9);
    @(negedge clk);
    checkCount++;
    if (inReady !== 1'b1 || busy !== 1'b0 || outValid !== 1'b0 || sawValid) begin
      errorCount++;
      $display("[TB] FAIL abort_to_idle got ready=%b busy=%b valid=%b seen=%b exp 1 0 0 0", inReady, busy, outValid, sawValid);
    end
    abortReq = 1'b0;
    expQ.push_back(12'hFC1);
    @(negedge clk);
    inValid = 1'b0;
    checkCount++;
    if (busy !== 1'b1 || rowIdx !== 3'd0) begin
      errorCount++;
      $display("[TB] FAIL abort_reaccept got busy=%b row=%0d exp 1 0", busy, rowIdx);
    end
    wait_valid(n, busyCnt);
    checkCount++;
    if (n != 5 || expQ.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL abort_new_latency got %0d exp 5", n);
    end else begin
      expV = expQ.pop_front();
      checkCount++;
      if (pOut !== expV) begin
        errorCount++;
        $display("[TB] FAIL abort_new_p got %h exp %h", pOut, expV);
      end
    end
    @(negedge clk);
    outReady = 1'b0;
    send_op(2, 3, 12'h006, ok);
    wait_valid(n, busyCnt);
    abortReq = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    abortReq = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_back());
    checkCount++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || n != 5) begin
      errorCount++;
      $display("[TB] FAIL abort_in_done got valid=%b ready=%b lat=%0d exp 0 1 5", outValid, inReady, n);
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] expV;
    bit ok;
    int n, busyCnt;
    send_op(20, -3, 12'hFC4, ok);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (busy !== 1'b0 || outValid !== 1'b0 || pOut !== 12'h000 || rowIdx !== 3'd0) begin
      errorCount++;
      $display("[TB] FAIL async_reset got busy=%b valid=%b p=%h row=%0d exp 0 0 000 0", busy, outValid, pOut, rowIdx);
    end
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkCount++;
    if (inReady !== 1'b1) begin
      errorCount++;
      $display("[TB] FAIL async_reset_ready got %b exp 1", inReady);
    end
    @(negedge clk);
    send_op(-1, -1, 12'h001, ok);
    wait_valid(n, busyCnt);
    checkCount++;
    if (n != 5 || expQ.size() == 0) begin
      errorCount++;
      $display("[TB] FAIL post_reset_latency got %0d exp 5", n);
    end else begin
      expV = expQ.pop_front();
      checkCount++;
      if (pOut !== expV) begin
        errorCount++;
        $display("[TB] FAIL post_reset_p got %h exp %h", pOut, expV);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [11:0] expV;
    bit ok;
    int n, busyCnt, startCycle, sweepErrors;
    sweepErrors = 0;
    outReady = 1'b1;
    startCycle = cycleCount;
    for (int a = -64; a < 64; a++) begin
      for (int b = -16; b < 16; b++) begin
        send_op(a, b, model(a, b), ok);
        wait_valid(n, busyCnt);
        checkCount++;
        if (!ok || n != 5 || expQ.size() == 0) begin
          errorCount++;
          $display("[TB] FAIL sweep_latency a=%0d b=%0d got %0d exp 5", a, b, n);
        end else begin
          expV = expQ.pop_front();
          checkCount++;
          if (pOut !== expV) begin
            errorCount++;
            sweepErrors++;
            if (sweepErrors <= 10) $display("[TB] FAIL sweep_p a=%0d b=%0d got %h exp %h", a, b, pOut, expV);
          end
        end
        @(negedge clk);
      end
    end
    checkCount++;
    if (cycleCount - startCycle != 4096 * 7) begin
      errorCount++;
      $display("[TB] FAIL sweep_throughput got %0d cycles exp %0d", cycleCount - startCycle, 4096 * 7);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
